memory_arbiter: RTL and testbench
=================================

Name: memory_arbiter

Overview:
- Shares the single memory_controller port between two requesters: CPU (port A, fetch/data) and front panel/loader (port B, examine/deposit).
- Arbitrates between the two ports, latches the winning request, and drives the controller's enable/address/data lines for one cycle.
- Waits for operation_done, returns read data and a one-cycle done pulse to the winner.
- A watchdog prevents a hung transaction from stalling both requesters.

Parameters:
- WORD_WIDTH, 12, width of address and data (matches memory_utils word).
- TIMEOUT_CYCLES, 16, maximum cycles in WAIT before abort; must be ≥4.

Ports:
- clk input 1 system clock, all flops on posedge
- reset input 1 asynchronous, active-high
- a_req input 1 port A request, level
- a_write input 1 1=write, 0=read
- a_read_type input 1 DATA_READ / INSTRUCTION_FETCH encoding per memory_utils
- a_address input WORD_WIDTH port A address
- a_write_data input WORD_WIDTH port A write data
- a_done output 1 one-cycle completion pulse
- a_read_data output WORD_WIDTH read result, valid while a_done=1
- b_req, b_write, b_read_type, b_address, b_write_data, b_done, b_read_data: same as port A, for port B
- mem_address output WORD_WIDTH to controller address
- mem_write_data output WORD_WIDTH to controller write_data
- mem_read_enable output 1 to controller read_enable
- mem_write_enable output 1 to controller write_enable
- mem_read_type output 1 to controller read_type
- mem_read_data input WORD_WIDTH from controller read_data
- mem_operation_done input 1 from controller operation_done
- busy output 1 high in every state except IDLE
- timeout_err output 1 sticky watchdog flag

Behaviour:
- Reset (async, high): state=IDLE, last_grant=B, all outputs 0, timeout counter 0.
- All outputs are registered. Requester payload is latched at grant, so changes after grant are ignored.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant that port.
  - Both requests: grant the port ≠ last_grant (round-robin). After reset, A wins the first tie.
  - On grant: latch address, write_data, write, read_type and grantee; update last_grant; go to ISSUE.
- ISSUE (exactly 1 cycle): mem_write_enable=write, or mem_read_enable=~write. mem_address, mem_write_data and mem_read_type come from the latch. Next state is WAIT. Enables drop to 0 on leaving ISSUE.
- WAIT:
  - mem_address, mem_write_data and mem_read_type stay stable; enables stay 0.
  - Counter increments each cycle.
  - On mem_operation_done=1: capture mem_read_data (reads) or 0 (writes); go to RESPOND.
  - If the counter reaches TIMEOUT_CYCLES first: set timeout_err=1, capture data 0, go to RESPOND.
- RESPOND (1 cycle): grantee's x_done=1 and x_read_data=captured data. The other port's done/data stay 0. Next state is IDLE; counter clears.
- x_read_data holds its value until that port's next RESPOND.
- Latency: request seen in IDLE at cycle 0 → ISSUE cycle 1 → controller READ/WRITE cycle 2 → controller DONE cycle 3 → x_done cycle 4.
- Requester rule: hold x_req and payload until x_done. x_req must be low in the cycle after x_done. It may reassert the following cycle. Minimum request spacing per port is 6 cycles when uncontended.
- mem_operation_done outside WAIT is ignored.
- A request arriving while busy is held by the requester and is considered at the next IDLE.
- Reset mid-operation: returns immediately to IDLE with all outputs 0, and no done pulse is issued. The controller has no reset; a stray operation_done after reset is ignored by the IDLE rule.
- timeout_err clears only on reset.

Test Plan:
- Port A read: A reads 0200 (preloaded 1234 octal) with a_read_type=INSTRUCTION_FETCH.
  - mem_read_enable high exactly cycle 1 with mem_address=0200.
  - a_done=1 at cycle 4 with a_read_data=1234.
  - b_done stays 0.
- Port B write then read: B writes 7777 to 0005, then reads 0005.
  - mem_write_enable high for 1 cycle.
  - b_done pulses after the write, then after the read with b_read_data=7777.
- Simultaneous requests from reset: A and B request in the same cycle (A reads 0010, B writes 0020).
  - A served first; B's ISSUE follows A's RESPOND+1.
  - Next tie goes to B, confirming round-robin alternation over 4 back-to-back transactions.
- Payload change after grant: A changes a_address from 0100 to 0300 during WAIT.
  - mem_address stays 0100 for the whole transaction.
- Watchdog: stub the controller to never assert operation_done, TIMEOUT_CYCLES=16.
  - a_done=1 with a_read_data=0 after 16 WAIT cycles.
  - timeout_err=1 and stays set; the next transaction proceeds normally.
- Async reset in WAIT: assert reset mid-transaction.
  - All outputs 0 immediately and busy=0.
  - No done pulse; late operation_done ignored.
  - A subsequent A request completes with correct data.

Source files
------------

// File: rtl/memory_arbiter.sv
// Two-port arbiter in front of the single memory controller port.
// Round-robin on ties, latched payload, one transaction in flight, watchdog.
module memory_arbiter #(
    parameter int WORD_WIDTH     = 12,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  a_req,
    input  logic                  a_write,
    input  logic                  a_read_type,
    input  logic [WORD_WIDTH-1:0] a_address,
    input  logic [WORD_WIDTH-1:0] a_write_data,
    output logic                  a_done,
    output logic [WORD_WIDTH-1:0] a_read_data,
    input  logic                  b_req,
    input  logic                  b_write,
    input  logic                  b_read_type,
    input  logic [WORD_WIDTH-1:0] b_address,
    input  logic [WORD_WIDTH-1:0] b_write_data,
    output logic                  b_done,
    output logic [WORD_WIDTH-1:0] b_read_data,
    output logic [WORD_WIDTH-1:0] mem_address,
    output logic [WORD_WIDTH-1:0] mem_write_data,
    output logic                  mem_read_enable,
    output logic                  mem_write_enable,
    output logic                  mem_read_type,
    input  logic [WORD_WIDTH-1:0] mem_read_data,
    input  logic                  mem_operation_done,
    output logic                  busy,
    output logic                  timeout_err
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

    state_t                state, state_n;
    logic                  last_b, last_b_n;
    logic                  grant_b, grant_b_n;
    logic                  wr, wr_n;
    logic [CW-1:0]         cnt, cnt_n;
    logic [WORD_WIDTH-1:0] addr_n, wdata_n, a_data_n, b_data_n, resp;
    logic                  rtype_n, ren_n, wen_n;
    logic                  a_done_n, b_done_n, busy_n, terr_n, pick_b;

    // Next-state and next-output computation; every output is registered below.
    always_comb begin
        state_n   = state;
        last_b_n  = last_b;
        grant_b_n = grant_b;
        wr_n      = wr;
        cnt_n     = cnt;
        addr_n    = mem_address;
        wdata_n   = mem_write_data;
        rtype_n   = mem_read_type;
        a_data_n  = a_read_data;
        b_data_n  = b_read_data;
        terr_n    = timeout_err;
        ren_n     = 1'b0;
        wen_n     = 1'b0;
        a_done_n  = 1'b0;
        b_done_n  = 1'b0;
        resp      = '0;
        // B wins if alone, or on a tie when A was served last.
        pick_b    = b_req & (~a_req | ~last_b);
        unique case (state)
            IDLE: begin
                if (a_req | b_req) begin
                    grant_b_n = pick_b;
                    last_b_n  = pick_b;
                    wr_n      = pick_b ? b_write      : a_write;
                    rtype_n   = pick_b ? b_read_type  : a_read_type;
                    addr_n    = pick_b ? b_address    : a_address;
                    wdata_n   = pick_b ? b_write_data : a_write_data;
                    ren_n     = ~wr_n;
                    wen_n     = wr_n;
                    state_n   = ISSUE;
                end
            end
            ISSUE: begin
                cnt_n   = '0;
                state_n = WAIT;
            end
            WAIT: begin
                if (mem_operation_done || cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                    if (mem_operation_done) begin
                        resp = wr ? '0 : mem_read_data;
                    end else begin
                        terr_n = 1'b1;
                    end
                    if (grant_b) begin
                        b_done_n = 1'b1;
                        b_data_n = resp;
                    end else begin
                        a_done_n = 1'b1;
                        a_data_n = resp;
                    end
                    state_n = RESPOND;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            RESPOND: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    // State, latched payload and registered outputs; reset clears all of them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            last_b           <= 1'b1;
            grant_b          <= 1'b0;
            wr               <= 1'b0;
            cnt              <= '0;
            mem_address      <= '0;
            mem_write_data   <= '0;
            mem_read_type    <= 1'b0;
            mem_read_enable  <= 1'b0;
            mem_write_enable <= 1'b0;
            a_done           <= 1'b0;
            b_done           <= 1'b0;
            a_read_data      <= '0;
            b_read_data      <= '0;
            busy             <= 1'b0;
            timeout_err      <= 1'b0;
        end else begin
            state            <= state_n;
            last_b           <= last_b_n;
            grant_b          <= grant_b_n;
            wr               <= wr_n;
            cnt              <= cnt_n;
            mem_address      <= addr_n;
            mem_write_data   <= wdata_n;
            mem_read_type    <= rtype_n;
            mem_read_enable  <= ren_n;
            mem_write_enable <= wen_n;
            a_done           <= a_done_n;
            b_done           <= b_done_n;
            a_read_data      <= a_data_n;
            b_read_data      <= b_data_n;
            busy             <= busy_n;
            timeout_err      <= terr_n;
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a small behavioural controller.
// Controller: enable seen at edge N, operation_done high for the cycle after edge N+1.
module tb_memory_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        a_req = 1'b0, a_write = 1'b0, a_read_type = 1'b0;
    logic [11:0] a_address = '0, a_write_data = '0;
    logic        a_done;
    logic [11:0] a_read_data;
    logic        b_req = 1'b0, b_write = 1'b0, b_read_type = 1'b0;
    logic [11:0] b_address = '0, b_write_data = '0;
    logic        b_done;
    logic [11:0] b_read_data;
    logic [11:0] mem_address, mem_write_data;
    logic        mem_read_enable, mem_write_enable, mem_read_type;
    logic [11:0] mem_read_data = '0;
    logic        mem_operation_done = 1'b0;
    logic        busy, timeout_err;

    logic [11:0] mem [0:4095];
    logic        stall = 1'b0;
    logic        pend = 1'b0;
    logic        pend_wr = 1'b0;
    logic [11:0] pend_addr = '0, pend_wd = '0;

    int n_checks = 0;
    int n_pass   = 0;

    memory_arbiter #(.WORD_WIDTH(12), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_write(a_write), .a_read_type(a_read_type),
        .a_address(a_address), .a_write_data(a_write_data),
        .a_done(a_done), .a_read_data(a_read_data),
        .b_req(b_req), .b_write(b_write), .b_read_type(b_read_type),
        .b_address(b_address), .b_write_data(b_write_data),
        .b_done(b_done), .b_read_data(b_read_data),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
        .mem_read_type(mem_read_type), .mem_read_data(mem_read_data),
        .mem_operation_done(mem_operation_done),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Behavioural controller; it has no reset, so a pending op survives arbiter reset.
    always @(posedge clk) begin
        mem_operation_done <= 1'b0;
        if (pend) begin
            pend               <= 1'b0;
            mem_operation_done <= 1'b1;
            if (pend_wr) mem[pend_addr] <= pend_wd;
            else         mem_read_data  <= mem[pend_addr];
        end
        if (!stall && (mem_read_enable || mem_write_enable)) begin
            pend      <= 1'b1;
            pend_wr   <= mem_write_enable;
            pend_addr <= mem_address;
            pend_wd   <= mem_write_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0o expected %0o", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        a_req = 1'b0;
        b_req = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    // One transaction on one port; request raised in the current cycle (cycle 0).
    task automatic txn(input string tag, input bit pb, input bit w, input logic rt,
                       input logic [11:0] ad, input logic [11:0] wd,
                       input logic [11:0] exp_data, input int exp_lat);
        int lat = 0, ren = 0, wen = 0, oth = 0;
        bit got = 1'b0;
        logic [11:0] d = '0;
        if (pb) begin
            b_write = w; b_read_type = rt; b_address = ad; b_write_data = wd; b_req = 1'b1;
        end else begin
            a_write = w; a_read_type = rt; a_address = ad; a_write_data = wd; a_req = 1'b1;
        end
        for (int c = 1; c <= 40 && !got; c++) begin
            step();
            ren += int'(mem_read_enable);
            wen += int'(mem_write_enable);
            if (pb ? a_done : b_done) oth++;
            if (pb ? b_done : a_done) begin
                got = 1'b1;
                lat = c;
                d   = pb ? b_read_data : a_read_data;
                if (pb) b_req = 1'b0;
                else    a_req = 1'b0;
            end
        end
        a_req = 1'b0;
        b_req = 1'b0;
        check({tag, "_done"}, 32'(got), 32'd1);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_data"}, 32'(d), 32'(exp_data));
        check({tag, "_ren"}, 32'(ren), 32'(!w));
        check({tag, "_wen"}, 32'(wen), 32'(w));
        check({tag, "_other_done"}, 32'(oth), 32'd0);
        step();
        step();
    endtask

    // Both ports keep requesting; done pulses must alternate starting with first_b.
    task automatic tie_run(input int total, input bit first_b);
        int n = 0, cyc = 0, an = 0, bn = 0;
        int a_next = -1, b_next = -1, a_done_cyc = -1, gap = -1;
        bit order [8];
        a_write = 1'b0; a_read_type = 1'b0; a_address = 12'o0010;
        b_write = 1'b1; b_read_type = 1'b0; b_address = 12'o0020; b_write_data = 12'o4321;
        a_req = 1'b1;
        b_req = 1'b1;
        while (n < total && cyc < 100) begin
            step();
            cyc++;
            if (mem_write_enable && a_done_cyc >= 0 && gap < 0) gap = cyc - a_done_cyc;
            if (a_done) begin
                order[n] = 1'b0; n++; an++;
                a_req = 1'b0; a_next = cyc + 2; a_done_cyc = cyc;
                check("tie_a_data", 32'(a_read_data), 32'o0055);
            end
            if (b_done) begin
                order[n] = 1'b1; n++; bn++;
                b_req = 1'b0; b_next = cyc + 2;
                check("tie_b_data", 32'(b_read_data), 32'd0);
            end
            if (!a_req && an < total / 2 && cyc == a_next) a_req = 1'b1;
            if (!b_req && bn < total / 2 && cyc == b_next) b_req = 1'b1;
        end
        a_req = 1'b0;
        b_req = 1'b0;
        check("tie_count", 32'(n), 32'(total));
        for (int i = 0; i < total; i++)
            check($sformatf("tie_order_%0d", i), 32'(order[i]), 32'(first_b ^ (i % 2 == 1)));
        if (!first_b) check("tie_b_issue_gap", 32'(gap), 32'd2);
        step();
        step();
    endtask

    initial begin
        bit moved;
        bit seen;
        int lat;
        mem[12'o0200] = 12'o1234;
        mem[12'o0010] = 12'o0055;
        mem[12'o0100] = 12'o1111;
        mem[12'o0300] = 12'o3333;
        mem[12'o0005] = 12'o0000;

        // Reset state
        step();
        step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_addr", 32'(mem_address), 32'd0);
        check("rst_ren", 32'(mem_read_enable), 32'd0);
        check("rst_terr", 32'(timeout_err), 32'd0);
        reset = 1'b0;
        step();

        // Port A instruction fetch, cycle-exact
        a_write = 1'b0; a_read_type = 1'b1; a_address = 12'o0200; a_req = 1'b1;
        step();
        check("a_rd_c1_ren", 32'(mem_read_enable), 32'd1);
        check("a_rd_c1_wen", 32'(mem_write_enable), 32'd0);
        check("a_rd_c1_addr", 32'(mem_address), 32'o0200);
        check("a_rd_c1_rtype", 32'(mem_read_type), 32'd1);
        check("a_rd_c1_busy", 32'(busy), 32'd1);
        step();
        check("a_rd_c2_ren", 32'(mem_read_enable), 32'd0);
        step();
        check("a_rd_c3_done", 32'(a_done), 32'd0);
        step();
        check("a_rd_c4_done", 32'(a_done), 32'd1);
        check("a_rd_c4_data", 32'(a_read_data), 32'o1234);
        check("a_rd_c4_bdone", 32'(b_done), 32'd0);
        a_req = 1'b0;
        step();
        check("a_rd_c5_done", 32'(a_done), 32'd0);
        check("a_rd_c5_busy", 32'(busy), 32'd0);
        check("a_rd_hold", 32'(a_read_data), 32'o1234);
        step();

        // Port B write then read back
        txn("b_wr", 1'b1, 1'b1, 1'b0, 12'o0005, 12'o7777, 12'o0000, 4);
        txn("b_rd", 1'b1, 1'b0, 1'b0, 12'o0005, 12'o0000, 12'o7777, 4);

        // Ties from reset: A first, then alternation; then a tie after A goes to B
        do_reset();
        tie_run(4, 1'b0);
        txn("a_between", 1'b0, 1'b0, 1'b0, 12'o0200, 12'o0, 12'o1234, 4);
        tie_run(2, 1'b1);

        // Payload change after grant must not reach the controller
        a_write = 1'b0; a_read_type = 1'b0; a_address = 12'o0100; a_req = 1'b1;
        moved = 1'b0;
        seen = 1'b0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            step();
            if (c == 2) a_address = 12'o0300;
            if (mem_address !== 12'o0100) moved = 1'b1;
            if (a_done) begin
                seen = 1'b1;
                check("payload_data", 32'(a_read_data), 32'o1111);
                a_req = 1'b0;
            end
        end
        a_req = 1'b0;
        check("payload_done", 32'(seen), 32'd1);
        check("payload_addr_stable", 32'(moved), 32'd0);
        step();
        step();

        // Watchdog: controller never answers
        stall = 1'b1;
        check("wd_terr_before", 32'(timeout_err), 32'd0);
        txn("wd", 1'b0, 1'b0, 1'b0, 12'o0200, 12'o0, 12'o0000, 18);
        check("wd_terr_set", 32'(timeout_err), 32'd1);
        stall = 1'b0;
        txn("wd_next", 1'b0, 1'b0, 1'b0, 12'o0010, 12'o0, 12'o0055, 4);
        check("wd_terr_sticky", 32'(timeout_err), 32'd1);

        // Async reset while in WAIT
        a_write = 1'b0; a_read_type = 1'b1; a_address = 12'o0200; a_req = 1'b1;
        step();
        step();
        check("ar_in_wait_busy", 32'(busy), 32'd1);
        a_req = 1'b0;
        reset = 1'b1;
        #1;
        check("ar_busy", 32'(busy), 32'd0);
        check("ar_addr", 32'(mem_address), 32'd0);
        check("ar_rtype", 32'(mem_read_type), 32'd0);
        check("ar_adata", 32'(a_read_data), 32'd0);
        check("ar_terr", 32'(timeout_err), 32'd0);
        #1;
        reset = 1'b0;
        seen = 1'b0;
        lat = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (a_done || b_done || busy || mem_read_enable) seen = 1'b1;
            if (mem_operation_done) lat++;
        end
        check("ar_no_activity", 32'(seen), 32'd0);
        check("ar_late_done_seen", 32'(lat), 32'd1);
        txn("ar_after", 1'b0, 1'b0, 1'b1, 12'o0200, 12'o0, 12'o1234, 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
